snk_rotary_ctrl: RTL

- Upstream input stage for the Athena/SNK core. Turns MiSTer player buttons or an analog-stick angle into the 12-position rotary-joystick code the CPU reads on the TRACKBALL1/TRACKBALL2 words.
- One instance per player. The output nibble is wired into the TRACKBALL input bits.
- All stepping is timed in enables of the player-control clock, so behaviour is independent of the 53.6 MHz master clock.

---
 rtl/snk_input_pkg.sv | 22 ++
 rtl/snk_rotary_target.sv | 23 ++
 rtl/snk_rotary_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/snk_input_pkg.sv
// Shared types and helpers for the SNK player input stage.
package snk_input_pkg;

  localparam int unsigned ROT_POSITIONS = 12;

  // Code the core expects for each rotary position; binary index.
  localparam logic [3:0] ROT_CODE [ROT_POSITIONS] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
    4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB
  };

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT, TRACK} rot_state_t;

  function automatic logic [3:0] rot_wrap_inc(input logic [3:0] p);
    return (p == 4'd11) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [3:0] rot_wrap_dec(input logic [3:0] p);
    return (p == 4'd0) ? 4'd11 : p - 4'd1;
  endfunction

endpackage

// File: rtl/snk_rotary_target.sv
// Maps an 8-bit stick angle to a rotary position and picks the shortest way there.
module snk_rotary_target (
  input  logic [7:0] angle,
  input  logic [3:0] pos,
  output logic [3:0] target,
  output logic [3:0] diff,
  output logic       dir_cw
);

  logic [11:0] prod;
  logic [4:0]  sum;

  // angle*12 never exceeds 12 bits, so the top nibble is always 0..11.
  always_comb begin
    prod   = 12'(angle) * 12'd12;
    target = 4'(prod >> 8);
    sum    = 5'(target) + 5'd12 - 5'(pos);
    diff   = 4'((sum >= 5'd12) ? sum - 5'd12 : sum);
    // Half-turn tie goes clockwise.
    dir_cw = (diff != 4'd0) && (diff <= 4'd6);
  end

endmodule

// File: rtl/snk_rotary_ctrl.sv
// Rotary joystick controller: buttons or analog stick -> 12-position rotary code.
module snk_rotary_ctrl
  import snk_input_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 64,
  parameter int unsigned REPEAT_DELAY = 256,
  parameter bit          INVERT_DIR   = 1'b0
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic       cen,
  input  logic       rot_cw,
  input  logic       rot_ccw,
  input  logic       analog_en,
  input  logic       analog_valid,
  input  logic [7:0] angle,
  output logic [3:0] pos,
  output logic [3:0] rot_n,
  output logic       step,
  output logic       moving
);

  localparam logic [9:0] STEP_LD   = 10'(STEP_DIV);
  localparam logic [9:0] REPEAT_LD = 10'(REPEAT_DELAY);

  rot_state_t state;
  logic [9:0] timer;
  logic       dir_q;
  logic       cw_i, ccw_i, dir_req;
  logic       timer_exp, track_go, move_cw;
  logic [3:0] target, diff, pos_step;
  logic       track_cw;

  snk_rotary_target u_target (
    .angle  (angle),
    .pos    (pos),
    .target (target),
    .diff   (diff),
    .dir_cw (track_cw)
  );

  // Input swap, request decode and the direction of whatever step this cen would take.
  always_comb begin
    cw_i      = INVERT_DIR ? rot_ccw : rot_cw;
    ccw_i     = INVERT_DIR ? rot_cw : rot_ccw;
    dir_req   = cw_i ^ ccw_i;
    // Timer expires when its decremented value would reach zero.
    timer_exp = (timer <= 10'd1);
    track_go  = analog_en && analog_valid && (diff != 4'd0);
    if (state == TRACK || (state == IDLE && track_go)) begin
      move_cw = track_cw;
    end else if (state == IDLE) begin
      move_cw = cw_i;
    end else begin
      move_cw = dir_q;
    end
    pos_step = move_cw ? rot_wrap_inc(pos) : rot_wrap_dec(pos);
  end

  // Main FSM; step is a one-clk pulse, everything else advances only on cen.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state  <= IDLE;
      timer  <= '0;
      dir_q  <= 1'b0;
      pos    <= '0;
      rot_n  <= 4'hF;
      step   <= 1'b0;
      moving <= 1'b0;
    end else begin
      step <= 1'b0;
      if (cen) begin
        unique case (state)
          IDLE: begin
            if (track_go) begin
              state  <= TRACK;
              timer  <= '0;
              pos    <= pos_step;
              rot_n  <= ~ROT_CODE[pos_step];
              step   <= 1'b1;
              moving <= 1'b1;
            end else if (!analog_en && dir_req) begin
              state  <= FIRST;
              timer  <= REPEAT_LD;
              dir_q  <= cw_i;
              pos    <= pos_step;
              rot_n  <= ~ROT_CODE[pos_step];
              step   <= 1'b1;
              moving <= 1'b1;
            end
          end
          FIRST, REPEAT: begin
            // A direction change drops to IDLE; IDLE re-triggers on the next cen.
            if (!dir_req || (cw_i != dir_q) || analog_en) begin
              state  <= IDLE;
              timer  <= '0;
              moving <= 1'b0;
            end else if (timer_exp) begin
              state <= REPEAT;
              timer <= STEP_LD;
              pos   <= pos_step;
              rot_n <= ~ROT_CODE[pos_step];
              step  <= 1'b1;
            end else begin
              timer <= timer - 10'd1;
            end
          end
          TRACK: begin
            if (!analog_en || !analog_valid || (diff == 4'd0)) begin
              state  <= IDLE;
              timer  <= '0;
              moving <= 1'b0;
            end else if (timer_exp) begin
              timer <= STEP_LD;
              pos   <= pos_step;
              rot_n <= ~ROT_CODE[pos_step];
              step  <= 1'b1;
            end else begin
              timer <= timer - 10'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
